// File: rtl/sap1_prog_loader.sv
// rtl/sap1_prog_loader.sv - streams a length-prefixed program into SAP-1 memory; LOADER_CHECKSUM_EN adds a trailing checksum byte
module sap1_prog_loader #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        IDLE, COUNT, DATA, WRITE, CSUM, DONE, ERROR
    } state_t;

    localparam logic [8:0]      MAX_N   = 9'(1 << ADDR_W);
    localparam logic [ADDR_W:0] IDX_ONE = (ADDR_W + 1)'(1);

    state_t            state_q;
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W:0]   idx_q;
    logic [ADDR_W:0]   idx_d;
    logic              in_ready_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [7:0]        mem_wdata_q;
    logic              cpu_hold_q;
    logic              done_q;
    logic              err_q;
    logic              accept;

    assign accept = in_valid && in_ready_q;
    assign idx_d  = idx_q + IDX_ONE;

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] sum_q;
    logic [7:0] sum_d;
    assign sum_d = sum_q + in_data;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            count_q     <= '0;
            idx_q       <= '0;
            in_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 8'h00;
            cpu_hold_q  <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum_q       <= 8'h00;
`endif
        end else begin
            mem_we_q <= 1'b0;
            case (state_q)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        state_q    <= COUNT;
                        in_ready_q <= 1'b1;
                        cpu_hold_q <= 1'b1;
                        done_q     <= 1'b0;
                        err_q      <= 1'b0;
                        idx_q      <= '0;
`ifdef LOADER_CHECKSUM_EN
                        sum_q      <= 8'h00;
`endif
                    end
                end
                COUNT: begin
                    if (accept) begin
                        if (in_data == 8'h00 || {1'b0, in_data} > MAX_N) begin
                            state_q    <= ERROR;
                            in_ready_q <= 1'b0;
                            cpu_hold_q <= 1'b0;
                            err_q      <= 1'b1;
                        end else begin
                            state_q <= DATA;
                            count_q <= in_data[ADDR_W:0];
`ifdef LOADER_CHECKSUM_EN
                            sum_q   <= in_data;
`endif
                        end
                    end
                end
                DATA: begin
                    // Strobe is registered here so it is high exactly during WRITE.
                    if (accept) begin
                        state_q     <= WRITE;
                        in_ready_q  <= 1'b0;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= idx_q[ADDR_W-1:0];
                        mem_wdata_q <= in_data;
`ifdef LOADER_CHECKSUM_EN
                        sum_q       <= sum_d;
`endif
                    end
                end
                WRITE: begin
                    idx_q <= idx_d;
                    if (idx_d == count_q) begin
`ifdef LOADER_CHECKSUM_EN
                        state_q    <= CSUM;
                        in_ready_q <= 1'b1;
`else
                        state_q    <= DONE;
                        cpu_hold_q <= 1'b0;
                        done_q     <= 1'b1;
`endif
                    end else begin
                        state_q    <= DATA;
                        in_ready_q <= 1'b1;
                    end
                end
                CSUM: begin
`ifdef LOADER_CHECKSUM_EN
                    if (accept) begin
                        in_ready_q <= 1'b0;
                        cpu_hold_q <= 1'b0;
                        if (sum_d == 8'h00) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ERROR;
                            err_q   <= 1'b1;
                        end
                    end
`else
                    state_q    <= IDLE;
                    in_ready_q <= 1'b0;
                    cpu_hold_q <= 1'b0;
`endif
                end
                default: begin
                    state_q    <= IDLE;
                    in_ready_q <= 1'b0;
                    cpu_hold_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_hold  = cpu_hold_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_sap1_prog_loader.sv
// tb/tb_sap1_prog_loader.sv - randomized self-checking bench for sap1_prog_loader against a byte-stream model
module tb_sap1_prog_loader;

    localparam int ADDR_W = 4;
    localparam int DEPTH  = 1 << ADDR_W;
`ifdef LOADER_CHECKSUM_EN
    localparam int CSUM_EN = 1;
`else
    localparam int CSUM_EN = 0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              cpu_hold;
    logic              done;
    logic              err;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0]        stim[$];
    logic [ADDR_W-1:0] wlog_a[$];
    logic [7:0]        wlog_d[$];

    sap1_prog_loader #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wlog_a.push_back(mem_addr);
            wlog_d.push_back(mem_wdata);
            n_checks++;
            if (in_ready !== 1'b0) $display("FAIL ready_in_write: in_ready=%b required 0", in_ready);
            else n_pass++;
        end
    end

    // Presents the first n bytes of stim, optionally with idle gaps and stray start pulses.
    task automatic drive(input int n, input bit gaps, input bit pulses);
        int i = 0;
        int guard = 0;
        int nlen;
        bit pend = 1'b0;
        logic [7:0] pend_d = 8'h00;
        nlen = (stim[0] == 8'h00 || int'(stim[0]) > DEPTH) ? 0 : int'(stim[0]);
        while (i < n && guard < 400) begin
            @(negedge clk);
            guard++;
            if (pend) begin
                n_checks++;
                if (mem_we !== 1'b1 || mem_wdata !== pend_d)
                    $display("FAIL write_latency: mem_we=%b wdata=%h required 1 %h", mem_we, mem_wdata, pend_d);
                else n_pass++;
                pend = 1'b0;
            end
            start = pulses && ($urandom_range(0, 3) == 0);
            if (gaps && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
            end else begin
                in_valid = 1'b1;
                in_data  = stim[i];
                if (in_ready === 1'b1) begin
                    pend   = (i >= 1 && i <= nlen);
                    pend_d = stim[i];
                    i++;
                end
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b0;
        n_checks++;
        if (i != n) $display("FAIL drive_timeout: accepted=%0d required %0d", i, n);
        else n_pass++;
        if (pend) begin
            n_checks++;
            if (mem_we !== 1'b1 || mem_wdata !== pend_d)
                $display("FAIL write_latency: mem_we=%b wdata=%h required 1 %h", mem_we, mem_wdata, pend_d);
            else n_pass++;
        end
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if ({cpu_hold, in_ready, done, err} !== 4'b1100)
            $display("FAIL start_state: hold/ready/done/err=%b required 1100", {cpu_hold, in_ready, done, err});
        else n_pass++;
    endtask

    // Model: decides from the stream alone which bytes are taken, what is written and how it ends.
    task automatic run_load(input string name, input bit gaps, input bit pulses);
        int nlen;
        int n_acc;
        int sum;
        int wait_n;
        bit exp_done;
        bit exp_err;
        nlen = int'(stim[0]);
        if (nlen == 0 || nlen > DEPTH) begin
            n_acc = 1; exp_done = 1'b0; exp_err = 1'b1;
        end else begin
            n_acc = 1 + nlen + CSUM_EN;
            sum = 0;
            for (int k = 0; k < n_acc; k++) sum += int'(stim[k]);
            exp_done = (CSUM_EN == 0) || (sum % 256 == 0);
            exp_err  = !exp_done;
        end
        do_start();
        wlog_a.delete();
        wlog_d.delete();
        drive(n_acc, gaps, pulses);
        wait_n = 0;
        while (done !== 1'b1 && err !== 1'b1 && wait_n < 8) begin
            @(negedge clk);
            wait_n++;
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if ({done, err, cpu_hold, in_ready} !== {exp_done, exp_err, 2'b00})
            $display("FAIL %s_end: done/err/hold/ready=%b required %b", name,
                     {done, err, cpu_hold, in_ready}, {exp_done, exp_err, 2'b00});
        else n_pass++;
        n_checks++;
        if (wlog_a.size() != ((n_acc == 1) ? 0 : nlen))
            $display("FAIL %s_nwrites: got %0d required %0d", name, wlog_a.size(), (n_acc == 1) ? 0 : nlen);
        else begin
            n_pass++;
            for (int k = 0; k < wlog_a.size(); k++) begin
                n_checks++;
                if (int'(wlog_a[k]) != k || wlog_d[k] !== stim[k + 1])
                    $display("FAIL %s_write%0d: addr=%0d data=%h required %0d %h", name, k,
                             wlog_a[k], wlog_d[k], k, stim[k + 1]);
                else n_pass++;
            end
        end
    endtask

    task automatic make_stream(input int nlen, input bit good);
        int sum = nlen;
        logic [7:0] b;
        stim.delete();
        stim.push_back(8'(nlen));
        for (int k = 0; k < nlen; k++) begin
            b = 8'($urandom);
            stim.push_back(b);
            sum += int'(b);
        end
        b = 8'((256 - (sum % 256)) % 256);
        if (!good) b = b + 8'($urandom_range(1, 255));
        stim.push_back(b);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, err} !== '0)
            $display("FAIL reset_values: ready=%b we=%b addr=%h wdata=%h hold=%b done=%b err=%b required all 0",
                     in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, err);
        else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        stim = '{8'h03, 8'h1E, 8'h2F, 8'hE0, 8'hD0};
        run_load("good3", 1'b0, 1'b0);
        stim = '{8'h03, 8'h1E, 8'h2F, 8'hE0, 8'hD1};
        run_load("badsum", 1'b0, 1'b0);
    endtask

    task automatic test_bad_count();
        stim = '{8'h00, 8'h55};
        run_load("count0", 1'b0, 1'b0);
        stim = '{8'h11, 8'h55};
        run_load("count17", 1'b0, 1'b0);
    endtask

    task automatic test_full_depth();
        make_stream(DEPTH, 1'b1);
        run_load("full16", 1'b0, 1'b0);
    endtask

    task automatic test_reset_midload();
        stim = '{8'h03, 8'h1E, 8'h2F};
        do_start();
        wlog_a.delete();
        wlog_d.delete();
        drive(3, 1'b0, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'hE0;
        start    = 1'b1;
        rst_n    = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, err} !== '0)
            $display("FAIL midreset_values: ready=%b we=%b addr=%h wdata=%h hold=%b done=%b err=%b required all 0",
                     in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, err);
        else n_pass++;
        start    = 1'b0;
        in_valid = 1'b0;
        rst_n    = 1'b1;
        repeat (5) @(negedge clk);
        n_checks++;
        if (wlog_a.size() != 2 || wlog_a[0] !== 4'd0 || wlog_d[0] !== 8'h1E ||
            wlog_a[1] !== 4'd1 || wlog_d[1] !== 8'h2F)
            $display("FAIL midreset_writes: got %0d writes required 2 (0:1e 1:2f)", wlog_a.size());
        else n_pass++;
        stim = '{8'h03, 8'h1E, 8'h2F, 8'hE0, 8'hD0};
        run_load("restart", 1'b0, 1'b0);
    endtask

    task automatic test_random_handshake();
        stim = '{8'h03, 8'h1E, 8'h2F, 8'hE0, 8'hD0};
        run_load("jitter3", 1'b1, 1'b1);
        for (int r = 0; r < 12; r++) begin
            make_stream($urandom_range(0, DEPTH + 2), $urandom_range(0, 3) != 0);
            run_load("random", 1'b1, 1'b1);
        end
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 4; r++) begin
            make_stream($urandom_range(1, DEPTH), 1'b1);
            run_load("b2b", 1'b0, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_bad_count();
        test_full_depth();
        test_reset_midload();
        test_random_handshake();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
